// File: rtl/calc1_sched_if.sv
// Bus bundle between the four calc1 requesters, the scheduler and the shared ALU port.
// The slave modport is the scheduler's view; master is the requester/ALU side.
interface calc1_sched_if;
  logic [0:3]  req1_cmd_in;
  logic [0:3]  req2_cmd_in;
  logic [0:3]  req3_cmd_in;
  logic [0:3]  req4_cmd_in;
  logic [0:31] req1_data_in;
  logic [0:31] req2_data_in;
  logic [0:31] req3_data_in;
  logic [0:31] req4_data_in;
  logic [0:1]  out_resp1;
  logic [0:1]  out_resp2;
  logic [0:1]  out_resp3;
  logic [0:1]  out_resp4;
  logic [0:31] out_data1;
  logic [0:31] out_data2;
  logic [0:31] out_data3;
  logic [0:31] out_data4;
  logic [0:3]  alu_cmd;
  logic [0:31] alu_data;
  logic [0:1]  alu_resp;
  logic [0:31] alu_data_in;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output alu_resp, alu_data_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4,
    input  alu_cmd, alu_data
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  alu_resp, alu_data_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4,
    output alu_cmd, alu_data
  );
endinterface

// File: rtl/calc1_sched.sv
// Four-port round-robin scheduler sharing one calc1 ALU port between four requesters.
// Optional WAIT timeout (response code 3) is enabled by defining CALC1_SCHED_TIMEOUT_EN.
module calc1_sched
`ifdef CALC1_SCHED_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 64)
`endif
(
  input logic          c_clk,
  input logic          reset,
  calc1_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2, WAIT} state_t;

  state_t      state, state_d;
  logic [1:0]  grant, grant_d;
  logic [1:0]  ptr, ptr_d;
  logic [1:0]  cand;
  logic        found;

  logic [0:3]  req_cmd  [4];
  logic [0:31] req_data [4];
  logic [0:3]  cmd_q    [4];
  logic [0:31] op1_q    [4];
  logic [0:31] op2_q    [4];
  logic [3:0]  capturing;
  logic [3:0]  pending;

  logic [0:3]  alu_cmd_q, alu_cmd_d;
  logic [0:31] alu_data_q, alu_data_d;
  logic [0:1]  resp_q  [4];
  logic [0:1]  resp_d  [4];
  logic [0:31] rdata_q [4];
  logic [0:31] rdata_d [4];

  logic        resp_hit;
  logic        timeout_hit;
  logic        done_hit;

  assign req_cmd[0]  = bus.req1_cmd_in;
  assign req_cmd[1]  = bus.req2_cmd_in;
  assign req_cmd[2]  = bus.req3_cmd_in;
  assign req_cmd[3]  = bus.req4_cmd_in;
  assign req_data[0] = bus.req1_data_in;
  assign req_data[1] = bus.req2_data_in;
  assign req_data[2] = bus.req3_data_in;
  assign req_data[3] = bus.req4_data_in;

  assign bus.out_resp1 = resp_q[0];
  assign bus.out_resp2 = resp_q[1];
  assign bus.out_resp3 = resp_q[2];
  assign bus.out_resp4 = resp_q[3];
  assign bus.out_data1 = rdata_q[0];
  assign bus.out_data2 = rdata_q[1];
  assign bus.out_data3 = rdata_q[2];
  assign bus.out_data4 = rdata_q[3];
  assign bus.alu_cmd   = alu_cmd_q;
  assign bus.alu_data  = alu_data_q;

  assign resp_hit = (state == WAIT) && (bus.alu_resp != '0);
  assign done_hit = resp_hit || timeout_hit;

`ifdef CALC1_SCHED_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counter restarts on every WAIT entry; the ALU response wins a same-cycle tie.
  assign timeout_hit = (state == WAIT) && (bus.alu_resp == '0) &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge c_clk) begin
    if (!reset || state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      ptr   <= ptr_d;
    end
  end

  // ptr is 0-based (0 = port 1); the search walks upward from it and wraps.
  always_comb begin
    state_d = state;
    grant_d = grant;
    ptr_d   = ptr;
    found   = 1'b0;
    cand    = '0;
    case (state)
      IDLE: begin
        for (int i = 0; i < 4; i++) begin
          cand = ptr + 2'(i);
          if (!found && pending[cand]) begin
            found   = 1'b1;
            grant_d = cand;
            ptr_d   = cand + 2'd1;
            state_d = ISSUE1;
          end
        end
      end
      ISSUE1:  state_d = ISSUE2;
      ISSUE2:  state_d = WAIT;
      WAIT:    if (done_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_cmd_d  = '0;
    alu_data_d = '0;
    for (int i = 0; i < 4; i++) begin
      resp_d[i]  = '0;
      rdata_d[i] = '0;
    end
    case (state_d)
      ISSUE1: begin
        alu_cmd_d  = cmd_q[grant_d];
        alu_data_d = op1_q[grant_d];
      end
      ISSUE2:  alu_data_d = op2_q[grant_d];
      default: ;
    endcase
    if (resp_hit) begin
      resp_d[grant]  = bus.alu_resp;
      rdata_d[grant] = bus.alu_data_in;
    end else if (timeout_hit) begin
      resp_d[grant]  = 2'd3;
    end
  end

  // A port that is capturing or pending ignores new commands.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      alu_cmd_q  <= '0;
      alu_data_q <= '0;
      capturing  <= '0;
      pending    <= '0;
      for (int i = 0; i < 4; i++) begin
        resp_q[i]  <= '0;
        rdata_q[i] <= '0;
        cmd_q[i]   <= '0;
        op1_q[i]   <= '0;
        op2_q[i]   <= '0;
      end
    end else begin
      alu_cmd_q  <= alu_cmd_d;
      alu_data_q <= alu_data_d;
      for (int i = 0; i < 4; i++) begin
        resp_q[i]  <= resp_d[i];
        rdata_q[i] <= rdata_d[i];
        if (capturing[i]) begin
          op2_q[i]     <= req_data[i];
          capturing[i] <= 1'b0;
          pending[i]   <= 1'b1;
        end else if (req_cmd[i] != '0 && !pending[i]) begin
          capturing[i] <= 1'b1;
          cmd_q[i]     <= req_cmd[i];
          op1_q[i]     <= req_data[i];
        end else if (done_hit && grant == 2'(i)) begin
          pending[i]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc1_sched.sv
// Self-checking bench for calc1_sched: directed scenarios plus random traffic against a
// transaction-level reference model; a small ALU responder model drives the shared port.
module tb_calc1_sched;

  logic c_clk = 1'b0;
  logic reset;
  calc1_sched_if bus();

`ifdef CALC1_SCHED_TIMEOUT_EN
  localparam int TMO = 8;
  calc1_sched #(.TIMEOUT_CYCLES(TMO)) dut (.c_clk(c_clk), .reset(reset), .bus(bus));
`else
  calc1_sched dut (.c_clk(c_clk), .reset(reset), .bus(bus));
`endif

  always #5 c_clk = ~c_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester scripts: each entry is {cmd, data} for one cycle.
  logic [35:0] sq [1:4][0:15];
  int          sq_n [1:4];
  logic [3:0]  d_cmd  [1:4];
  logic [31:0] d_data [1:4];

  // Reference model state.
  bit          m_cap  [1:4];
  bit          m_pend [1:4];
  logic [3:0]  m_cmd  [1:4];
  logic [31:0] m_op1  [1:4];
  logic [31:0] m_op2  [1:4];
  int          m_ptr, m_g, m_age;
  bit          m_busy;
  logic [3:0]  e_alu_cmd;
  logic [31:0] e_alu_data;
  logic [1:0]  e_resp [1:4];
  logic [31:0] e_data [1:4];

  // ALU responder model.
  int          env_stage, env_cnt, env_lat, env_issues;
  bit          env_mute, spurious_en;
  logic [3:0]  env_cmd;
  logic [31:0] env_op1, env_op2, env_res;
  logic [1:0]  env_resp;

  int          log_port [$];
  logic [31:0] log_resp [$];
  logic [31:0] log_data [$];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] obsResp(input int p);
    case (p)
      1:       return 32'(bus.out_resp1);
      2:       return 32'(bus.out_resp2);
      3:       return 32'(bus.out_resp3);
      default: return 32'(bus.out_resp4);
    endcase
  endfunction

  function automatic logic [31:0] obsData(input int p);
    case (p)
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      3:       return bus.out_data3;
      default: return bus.out_data4;
    endcase
  endfunction

  task automatic pushReq(input int p, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
    sq[p][sq_n[p]] = {c, a};
    sq_n[p]++;
    sq[p][sq_n[p]] = {4'd0, b};
    sq_n[p]++;
  endtask

  // One clock edge of the scheduler as seen from outside: who is granted, what the ALU
  // sees, which port gets a response. Uses pre-edge pending flags throughout.
  task automatic modelStep(input bit rst_n, input logic [1:0] ar, input logic [31:0] ad);
    bit old_pend [1:4];
    int c;
    for (int p = 1; p <= 4; p++) begin
      e_resp[p] = '0;
      e_data[p] = '0;
    end
    if (!rst_n) begin
      for (int p = 1; p <= 4; p++) begin
        m_cap[p]  = 1'b0;
        m_pend[p] = 1'b0;
      end
      m_ptr      = 1;
      m_busy     = 1'b0;
      e_alu_cmd  = '0;
      e_alu_data = '0;
      return;
    end
    old_pend = m_pend;
    if (m_busy) begin
      if (m_age >= 2 && ar != 2'd0) begin
        e_resp[m_g] = ar;
        e_data[m_g] = ad;
        m_pend[m_g] = 1'b0;
        m_busy      = 1'b0;
      end
`ifdef CALC1_SCHED_TIMEOUT_EN
      else if (m_age >= 2 && m_age - 1 == TMO) begin
        e_resp[m_g] = 2'd3;
        e_data[m_g] = '0;
        m_pend[m_g] = 1'b0;
        m_busy      = 1'b0;
      end
`endif
      else begin
        m_age++;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        c = (m_ptr - 1 + i) % 4 + 1;
        if (!m_busy && old_pend[c]) begin
          m_busy = 1'b1;
          m_g    = c;
          m_age  = 0;
          m_ptr  = c % 4 + 1;
        end
      end
    end
    e_alu_cmd  = (m_busy && m_age == 0) ? m_cmd[m_g] : 4'd0;
    e_alu_data = !m_busy ? 32'd0 : (m_age == 0) ? m_op1[m_g] : (m_age == 1) ? m_op2[m_g] : 32'd0;
    for (int p = 1; p <= 4; p++) begin
      if (m_cap[p]) begin
        m_op2[p]  = d_data[p];
        m_cap[p]  = 1'b0;
        m_pend[p] = 1'b1;
      end else if (d_cmd[p] != 4'd0 && !old_pend[p]) begin
        m_cap[p] = 1'b1;
        m_cmd[p] = d_cmd[p];
        m_op1[p] = d_data[p];
      end
    end
  endtask

  task automatic applyStimulus(input bit rst_n);
    logic [1:0]  ar;
    logic [31:0] ad;
    logic [32:0] s;
    for (int p = 1; p <= 4; p++) begin
      if (sq_n[p] > 0) begin
        d_cmd[p]  = sq[p][0][35:32];
        d_data[p] = sq[p][0][31:0];
        for (int j = 0; j < 15; j++) sq[p][j] = sq[p][j+1];
        sq_n[p]--;
      end else begin
        d_cmd[p]  = 4'd0;
        d_data[p] = $urandom;
      end
    end
    ar = 2'd0;
    ad = $urandom;
    if (env_stage == 2) begin
      env_cnt--;
      if (env_cnt == 0) begin
        env_stage = 0;
        if (!env_mute) begin
          ar = env_resp;
          ad = env_res;
        end
      end
    end else if (env_stage == 0 && spurious_en && $urandom_range(0, 7) == 0) begin
      ar = 2'($urandom_range(1, 3));
    end
    reset = rst_n;
    bus.req1_cmd_in  = d_cmd[1];
    bus.req2_cmd_in  = d_cmd[2];
    bus.req3_cmd_in  = d_cmd[3];
    bus.req4_cmd_in  = d_cmd[4];
    bus.req1_data_in = d_data[1];
    bus.req2_data_in = d_data[2];
    bus.req3_data_in = d_data[3];
    bus.req4_data_in = d_data[4];
    bus.alu_resp     = ar;
    bus.alu_data_in  = ad;
    modelStep(rst_n, ar, ad);
    @(posedge c_clk);
    @(negedge c_clk);
    checkOutput("alu_cmd", 32'(bus.alu_cmd), 32'(e_alu_cmd));
    checkOutput("alu_data", bus.alu_data, e_alu_data);
    for (int p = 1; p <= 4; p++) begin
      checkOutput($sformatf("out_resp%0d", p), obsResp(p), 32'(e_resp[p]));
      checkOutput($sformatf("out_data%0d", p), obsData(p), e_data[p]);
      if (obsResp(p) != 32'd0) begin
        log_port.push_back(p);
        log_resp.push_back(obsResp(p));
        log_data.push_back(obsData(p));
      end
    end
    if (env_stage == 1) begin
      env_op2 = bus.alu_data;
      case (env_cmd)
        4'd1: begin
          s        = {1'b0, env_op1} + {1'b0, env_op2};
          env_resp = s[32] ? 2'd2 : 2'd1;
          env_res  = s[32] ? 32'd0 : s[31:0];
        end
        4'd2: begin
          env_resp = (env_op2 > env_op1) ? 2'd2 : 2'd1;
          env_res  = (env_op2 > env_op1) ? 32'd0 : env_op1 - env_op2;
        end
        default: begin
          env_resp = 2'd2;
          env_res  = 32'd0;
        end
      endcase
      env_cnt   = (env_lat != 0) ? env_lat : $urandom_range(2, 5);
      env_stage = 2;
    end else if (env_stage == 0 && bus.alu_cmd != 4'd0) begin
      env_cmd   = bus.alu_cmd;
      env_op1   = bus.alu_data;
      env_stage = 1;
      env_issues++;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1);
  endtask

  task automatic runUntil(input int n_resp, input int max_cycles);
    for (int i = 0; i < max_cycles && log_port.size() < n_resp; i++) applyStimulus(1'b1);
    checkOutput("resp_count", log_port.size(), n_resp);
  endtask

  task automatic checkLog(input int idx, input int port, input logic [31:0] resp,
                          input logic [31:0] data, input bit check_data);
    if (idx < log_port.size()) begin
      checkOutput($sformatf("log%0d_port", idx), log_port[idx], port);
      checkOutput($sformatf("log%0d_resp", idx), log_resp[idx], resp);
      if (check_data) checkOutput($sformatf("log%0d_data", idx), log_data[idx], data);
    end else begin
      checkOutput($sformatf("log%0d_missing", idx), log_port.size(), idx + 1);
    end
  endtask

  task automatic clearLog();
    log_port.delete();
    log_resp.delete();
    log_data.delete();
  endtask

  task automatic doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0);
    clearLog();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int issues0;
    int exp_order1 [4];
    int exp_order2 [4];
    exp_order1 = '{1, 2, 3, 4};
    exp_order2 = '{2, 3, 4, 1};
    for (int p = 1; p <= 4; p++) sq_n[p] = 0;
    env_stage = 0; env_lat = 0; env_issues = 0; env_mute = 1'b0; spurious_en = 1'b0;
    m_ptr = 1; m_busy = 1'b0;

    doReset();
    checkOutput("rst_alu_cmd", 32'(bus.alu_cmd), 32'd0);
    checkOutput("rst_out_resp1", obsResp(1), 32'd0);

    $display("[TB] single add on port 1");
    pushReq(1, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
    runUntil(1, 30);
    checkLog(0, 1, 32'd1, 32'h2000_0000, 1'b1);
    checkOutput("add_alu_cmd", 32'(env_cmd), 32'd1);
    checkOutput("add_alu_op1", env_op1, 32'h0000_0001);
    checkOutput("add_alu_op2", env_op2, 32'h1FFF_FFFF);
    runCycles(3);
    checkOutput("add_single_resp", log_port.size(), 1);

    $display("[TB] four simultaneous requests");
    doReset();
    for (int p = 1; p <= 4; p++) pushReq(p, (p % 2 == 1) ? 4'd1 : 4'd2, 32'(100 * p), 32'(p));
    runUntil(4, 80);
    for (int i = 0; i < 4; i++)
      checkLog(i, exp_order1[i], 32'd1,
               (exp_order1[i] % 2 == 1) ? 32'(101 * exp_order1[i]) : 32'(99 * exp_order1[i]), 1'b1);
    clearLog();
    pushReq(1, 4'd1, 32'd7, 32'd8);
    runUntil(1, 30);
    checkLog(0, 1, 32'd1, 32'd15, 1'b1);
    clearLog();
    for (int p = 1; p <= 4; p++) pushReq(p, 4'd1, 32'(p), 32'd1000);
    runUntil(4, 80);
    for (int i = 0; i < 4; i++) checkLog(i, exp_order2[i], 32'd1, 32'(1000 + exp_order2[i]), 1'b1);
    clearLog();

    $display("[TB] overflow passthrough on port 3");
    pushReq(3, 4'd1, 32'hFFFF_FFFF, 32'd1);
    runUntil(1, 30);
    checkLog(0, 3, 32'd2, 32'd0, 1'b0);
    clearLog();

    $display("[TB] second command while pending on port 2");
    issues0 = env_issues;
    pushReq(2, 4'd1, 32'd5, 32'd6);
    pushReq(2, 4'd2, 32'd50, 32'd1);
    runUntil(1, 30);
    runCycles(12);
    checkOutput("viol_resp_count", log_port.size(), 1);
    checkLog(0, 2, 32'd1, 32'd11, 1'b1);
    checkOutput("viol_alu_issues", env_issues - issues0, 1);
    clearLog();

    $display("[TB] reset during WAIT");
    env_lat = 5;
    pushReq(1, 4'd1, 32'd3, 32'd4);
    for (int i = 0; i < 10 && env_stage != 2; i++) applyStimulus(1'b1);
    checkOutput("rst_reached_issue", env_stage, 2);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("midrst_alu_data", bus.alu_data, 32'd0);
    checkOutput("midrst_out_resp1", obsResp(1), 32'd0);
    runCycles(8);
    checkOutput("late_resp_ignored", log_port.size(), 0);
    env_lat = 0;
    pushReq(4, 4'd2, 32'd40, 32'd2);
    runUntil(1, 30);
    checkLog(0, 4, 32'd1, 32'd38, 1'b1);
    clearLog();

`ifdef CALC1_SCHED_TIMEOUT_EN
    $display("[TB] timeout with silent ALU");
    env_mute = 1'b1;
    pushReq(1, 4'd1, 32'd1, 32'd2);
    pushReq(2, 4'd1, 32'd3, 32'd4);
    runUntil(2, 80);
    checkLog(0, 1, 32'd3, 32'd0, 1'b1);
    checkLog(1, 2, 32'd3, 32'd0, 1'b1);
    env_mute = 1'b0;
    runCycles(8);
    clearLog();
`endif

    $display("[TB] random traffic");
    spurious_en = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 1; p <= 4; p++) begin
        if (sq_n[p] == 0 && $urandom_range(0, 5) == 0) begin
          pushReq(p, 4'($urandom_range(1, 15)),
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
                  $urandom);
          if ($urandom_range(0, 3) == 0) sq[p][1][35:32] = 4'($urandom_range(1, 15));
        end
      end
      applyStimulus(1'b1);
    end
    spurious_en = 1'b0;
    runCycles(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
